// File: rtl/usb_rx_bit_decoder_if.sv
// usb_rx_bit_decoder_if: raw USB pin inputs and the decoded serial stream
// produced by the receive front end. The decoder attaches as slave.
interface usb_rx_bit_decoder_if;
    logic d_plus_in;
    logic d_minus_in;
    logic d_orig;
    logic shift_enable;
    logic eop;
    logic stuff_error;

    modport master (
        output d_plus_in,
        output d_minus_in,
        input  d_orig,
        input  shift_enable,
        input  eop,
        input  stuff_error
    );

    modport slave (
        input  d_plus_in,
        input  d_minus_in,
        output d_orig,
        output shift_enable,
        output eop,
        output stuff_error
    );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: USB receive front end. Synchronizes D+/D-, recovers
// bit timing from D+ transitions, NRZI-decodes, strips stuffed bits and
// detects SE0 end-of-packet. Emits d_orig with a one-cycle shift_enable
// strobe per data bit.
// Optional feature: define USB_RX_STUFF_ERR_EN to flag a seventh consecutive
// 1 as a stuffing violation (stuff_error pulse, packet abandoned until EOP).
// Without it stuff_error is tied low and the seventh 1 is passed as data.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input logic                 clk,
    input logic                 n_rst,
    usb_rx_bit_decoder_if.slave rx_if
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMR_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_SAMPLE = TW'(SAMPLE_POINT);

    typedef enum logic [1:0] {IDLE, DATA, SE0_SEEN} state_e;

    state_e        state_q, state_d;
    logic          dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q, dp_prev_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          prev_level_q, prev_level_d;
    logic [2:0]    ones_q, ones_d;
    logic [1:0]    se0_cnt_q, se0_cnt_d;
    logic          d_orig_q, d_orig_d;
    logic          shift_en_q, shift_en_d;
    logic          eop_q, eop_d;

    logic edge_det, sample, se0, eop_hit, line_bit, nrzi_bit, accept;
    logic stuff_err_hit, locked;

    assign edge_det = dp_sync_q ^ dp_prev_q;
    assign sample   = (timer_q == TMR_SAMPLE);
    assign se0      = ~dp_sync_q & ~dm_sync_q;
    assign eop_hit  = sample & ~se0 & (se0_cnt_q >= 2'd2);
    assign line_bit = sample & ~se0 & ~eop_hit;
    assign nrzi_bit = (dp_sync_q == prev_level_q);
    // Outside IDLE every J/K bit is data; from IDLE only a K opens a packet.
    assign accept   = line_bit & ((state_q != IDLE) | (~dp_sync_q & ~locked));

`ifdef USB_RX_STUFF_ERR_EN
    logic lock_q, lock_d;
    logic stuff_err_q;

    assign stuff_err_hit     = accept & nrzi_bit & (ones_q == 3'd6);
    assign locked            = lock_q;
    assign rx_if.stuff_error = stuff_err_q;

    // After a violation the packet is abandoned; only an EOP re-arms reception.
    always_comb begin
        lock_d = lock_q;
        if (stuff_err_hit)
            lock_d = 1'b1;
        else if (eop_hit)
            lock_d = 1'b0;
    end

    // Violation flag register and pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lock_q      <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            stuff_err_q <= stuff_err_hit;
        end
    end
`else
    assign stuff_err_hit     = 1'b0;
    assign locked            = 1'b0;
    assign rx_if.stuff_error = 1'b0;
`endif

    assign rx_if.d_orig       = d_orig_q;
    assign rx_if.shift_enable = shift_en_q;
    assign rx_if.eop          = eop_q;

    // Two-flop synchronizers on both pins plus the previous synced D+ for edge detect.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            dp_prev_q <= 1'b1;
        end else begin
            dp_meta_q <= rx_if.d_plus_in;
            dp_sync_q <= dp_meta_q;
            dm_meta_q <= rx_if.d_minus_in;
            dm_sync_q <= dm_meta_q;
            dp_prev_q <= dp_sync_q;
        end
    end

    // Bit timer: an edge re-aligns the timer and beats the wrap.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (edge_det)
            timer_d = '0;
        else if (timer_q == TMR_LAST)
            timer_d = '0;
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = DATA;
            end
            DATA: begin
                if (sample & se0)
                    state_d = SE0_SEEN;
                else if (stuff_err_hit)
                    state_d = IDLE;
            end
            SE0_SEEN: begin
                if (eop_hit)
                    state_d = IDLE;
                else if (stuff_err_hit)
                    state_d = IDLE;
                else if (accept)
                    state_d = DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample classification, NRZI decode, unstuffing and output strobes.
    always_comb begin
        prev_level_d = prev_level_q;
        ones_d       = ones_q;
        se0_cnt_d    = se0_cnt_q;
        d_orig_d     = d_orig_q;
        shift_en_d   = 1'b0;
        eop_d        = 1'b0;
        if (sample & se0) begin
            if (se0_cnt_q != 2'd3)
                se0_cnt_d = se0_cnt_q + 2'd1;
            eop_d = (se0_cnt_q == 2'd1);
        end else if (eop_hit) begin
            se0_cnt_d    = 2'd0;
            prev_level_d = 1'b1;
            ones_d       = 3'd0;
        end else if (line_bit) begin
            se0_cnt_d    = 2'd0;
            prev_level_d = dp_sync_q;
            if (stuff_err_hit) begin
                ones_d = 3'd0;
            end else if (accept) begin
                if (nrzi_bit) begin
                    shift_en_d = 1'b1;
                    d_orig_d   = 1'b1;
                    if (ones_q != 3'd6)
                        ones_d = ones_q + 3'd1;
                end else begin
                    // A 0 after six 1s is the transmitter's stuffed bit.
                    ones_d = 3'd0;
                    if (ones_q != 3'd6) begin
                        shift_en_d = 1'b1;
                        d_orig_d   = 1'b0;
                    end
                end
            end
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q      <= '0;
            prev_level_q <= 1'b1;
            ones_q       <= 3'd0;
            se0_cnt_q    <= 2'd0;
            d_orig_q     <= 1'b1;
            shift_en_q   <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            prev_level_q <= prev_level_d;
            ones_q       <= ones_d;
            se0_cnt_q    <= se0_cnt_d;
            d_orig_q     <= d_orig_d;
            shift_en_q   <= shift_en_d;
            eop_q        <= eop_d;
        end
    end
endmodule
